ddr_frame_reader: RTL and testbench
===================================

Name: ddr_frame_reader

Overview:
- Read-side DDR master for one video slave channel; consumes the `rd_load`/`rd_bank` pair produced by the bank switch controller and returns `frame_rd_done` to it.
- On each load it reads one full frame from the selected DDR bank as fixed-length read bursts. It issues one outstanding burst at a time and throttles on the downstream FIFO's almost-full flag.
- Sits between the bank switch and the DDR user-interface arbiter; returned data goes straight to the read FIFO.

Parameters:
- ADDR_W, 25, DDR word-address width; bank occupies bits [ADDR_W-1:ADDR_W-2].
- BURST_LEN, 64, data beats per read burst; power of two, ≥2.
- FRAME_BURSTS, 4800, bursts per frame; ≥1.
- CNT_W, 13, burst-counter width; must satisfy 2^CNT_W > FRAME_BURSTS.

Ports:
- ddr_clk  in  1  sole clock.
- sys_rst  in  1  synchronous, active-high reset.
- rd_load  in  1  1-cycle pulse: start reading frame in rd_bank.
- rd_bank  in  2  bank to read; sampled only when rd_load=1.
- fifo_afull  in  1  downstream FIFO cannot accept another BURST_LEN beats.
- cmd_valid  out  1  read command request.
- cmd_ready  in  1  arbiter accepts command when cmd_valid&cmd_ready.
- cmd_addr  out  ADDR_W  {bank, burst_idx*BURST_LEN}, start word address of burst.
- rdata_valid  in  1  one returned data beat (data path bypasses this block).
- frame_rd_done  out  1  1-cycle pulse, frame fully returned.
- busy  out  1  high in any state other than IDLE.
- rd_err  out  1  sticky; rdata_valid seen outside DATA state.

Behaviour:
- Reset: all outputs 0; state IDLE; burst_idx=0; beat_cnt=0; pending=0; cur_bank=0.
- IDLE: on rd_load, cur_bank<=rd_bank, burst_idx<=0, go WAIT_SPACE next cycle.
- WAIT_SPACE: if fifo_afull=0, go REQ.
- REQ:
  - cmd_valid=1 and cmd_addr stable until accepted.
  - On cmd_valid&cmd_ready, cmd_valid drops the next cycle, beat_cnt<=0, go DATA.
  - cmd_valid never deasserts without acceptance, even if fifo_afull rises.
- DATA:
  - Count rdata_valid beats.
  - On beat BURST_LEN, if burst_idx=FRAME_BURSTS-1, go DONE; else burst_idx+1 and go WAIT_SPACE.
- DONE:
  - frame_rd_done=1 for exactly this one cycle.
  - If pending=1, load cur_bank<=pend_bank, clear pending, burst_idx<=0, go WAIT_SPACE. Otherwise go IDLE.
- rd_load while busy:
  - Latched into pend_bank/pending; a later rd_load overwrites pend_bank (last wins).
  - The current frame is never aborted.
  - rd_load in the DONE cycle also sets pending.
- Address arithmetic: offset = burst_idx × BURST_LEN, zero-extended to ADDR_W-2 bits; wraps silently if it overflows. Bank bits always come from cur_bank, never from the live rd_bank.
- Latency:
  - rd_load→cmd_valid is 2 cycles when fifo_afull=0.
  - Last beat→frame_rd_done is 1 cycle.
- Extra beats: rdata_valid in IDLE/WAIT_SPACE/REQ/DONE sets rd_err and is not counted. rd_err clears only on sys_rst.
- Reset mid-frame: immediate return to reset state with no done pulse. Outstanding beats after reset set rd_err.

Optional Feature:
- Macro: FRAME_RD_LOOP_EN.
- Defined: in DONE with pending=0, restart the same cur_bank (burst_idx<=0, go WAIT_SPACE) instead of IDLE. The display refreshes continuously until a new rd_load, which still takes effect at the next frame boundary. busy stays high after the first load.
- Undefined: behaviour exactly as above.

Test Plan (BURST_LEN=8, FRAME_BURSTS=4, ADDR_W=25, cmd_ready=1, one rdata_valid per cycle after acceptance unless stated):
- rd_load with rd_bank=2 → cmd_addr 0x1000000, 0x1000008, 0x1000010, 0x1000018; 32 beats; single frame_rd_done one cycle after beat 32; busy=0 afterwards.
- fifo_afull=1 held 20 cycles after burst 1 → no cmd_valid during hold; burst 2 issued 2 cycles after afull falls; total beats 32, one done pulse.
- cmd_ready low 5 cycles in REQ → cmd_valid and cmd_addr held constant for all 6 cycles; exactly one acceptance.
- rd_load bank=1 mid-frame of bank 0, then rd_load bank=3 → frame 0 completes untouched; next frame addresses carry bank 3 (0x1800000…); bank 1 never read.
- Extra rdata_valid while IDLE → rd_err=1 and stays 1; sys_rst mid-frame → cmd_valid=0, busy=0, no frame_rd_done the following cycle.
- FRAME_RD_LOOP_EN defined, single rd_load bank=0 → frames repeat at 0x0000000; done pulse every 32 beats; busy remains 1.

Source files
------------

// File: rtl/ddr_frame_reader_if.sv
// ddr_frame_reader_if: read-command channel and returned-beat strobe
// between the frame reader and the DDR user-interface arbiter.
interface ddr_frame_reader_if #(
  parameter int ADDR_W = 25
) ();
  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_addr;
  logic              rdata_valid;

  modport master (
    output cmd_valid,
    output cmd_addr,
    input  cmd_ready,
    input  rdata_valid
  );

  modport slave (
    input  cmd_valid,
    input  cmd_addr,
    output cmd_ready,
    output rdata_valid
  );
endinterface

// File: rtl/ddr_frame_reader.sv
// ddr_frame_reader: reads one frame per load as fixed-length DDR bursts.
// Optional FRAME_RD_LOOP_EN: replay cur_bank while no new load is pending.
module ddr_frame_reader #(
  parameter int ADDR_W       = 25,
  parameter int BURST_LEN    = 64,
  parameter int FRAME_BURSTS = 4800,
  parameter int CNT_W        = 13
) (
  input  logic               ddr_clk,
  input  logic               sys_rst,
  input  logic               rd_load,
  input  logic [1:0]         rd_bank,
  input  logic               fifo_afull,
  ddr_frame_reader_if.master ddr,
  output logic               frame_rd_done,
  output logic               busy,
  output logic               rd_err
);

  localparam int BL_W  = $clog2(BURST_LEN);
  localparam int OFF_W = ADDR_W - 2;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_SPACE,
    REQ,
    DATA,
    DONE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] burst_idx;
  logic [BL_W-1:0]  beat_cnt;
  logic             pending;
  logic [1:0]       pend_bank;
  logic [1:0]       cur_bank;
  logic [OFF_W-1:0] offset;
  logic             last_beat;
  logic             last_burst;

  // Offset wraps silently once it no longer fits below the bank bits.
  assign offset     = OFF_W'(burst_idx) << BL_W;
  assign last_beat  = beat_cnt == BL_W'(BURST_LEN - 1);
  assign last_burst = burst_idx == CNT_W'(FRAME_BURSTS - 1);

  always_ff @(posedge ddr_clk) begin
    if (sys_rst) begin
      state         <= IDLE;
      burst_idx     <= '0;
      beat_cnt      <= '0;
      pending       <= 1'b0;
      pend_bank     <= 2'd0;
      cur_bank      <= 2'd0;
      ddr.cmd_valid <= 1'b0;
      ddr.cmd_addr  <= '0;
      frame_rd_done <= 1'b0;
      busy          <= 1'b0;
      rd_err        <= 1'b0;
    end else begin
      frame_rd_done <= 1'b0;

      if (ddr.rdata_valid && state != DATA)
        rd_err <= 1'b1;

      // Loads while busy queue up; the last one wins.
      if (rd_load && state != IDLE) begin
        pending   <= 1'b1;
        pend_bank <= rd_bank;
      end

      case (state)
        IDLE: begin
          if (rd_load) begin
            cur_bank  <= rd_bank;
            burst_idx <= '0;
            busy      <= 1'b1;
            state     <= WAIT_SPACE;
          end
        end
        WAIT_SPACE: begin
          if (!fifo_afull) begin
            ddr.cmd_valid <= 1'b1;
            ddr.cmd_addr  <= {cur_bank, offset};
            state         <= REQ;
          end
        end
        REQ: begin
          if (ddr.cmd_ready) begin
            ddr.cmd_valid <= 1'b0;
            beat_cnt      <= '0;
            state         <= DATA;
          end
        end
        DATA: begin
          if (ddr.rdata_valid) begin
            beat_cnt <= beat_cnt + 1'b1;
            if (last_beat) begin
              if (last_burst) begin
                frame_rd_done <= 1'b1;
                state         <= DONE;
              end else begin
                burst_idx <= burst_idx + 1'b1;
                state     <= WAIT_SPACE;
              end
            end
          end
        end
        DONE: begin
          // A load arriving in this very cycle is honoured immediately.
          if (pending || rd_load) begin
            cur_bank  <= rd_load ? rd_bank : pend_bank;
            pending   <= 1'b0;
            burst_idx <= '0;
            state     <= WAIT_SPACE;
          end else begin
`ifdef FRAME_RD_LOOP_EN
            burst_idx <= '0;
            state     <= WAIT_SPACE;
`else
            busy      <= 1'b0;
            state     <= IDLE;
`endif
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ddr_frame_reader.sv
// tb_ddr_frame_reader: directed checks of the frame reader with
// BURST_LEN=8, FRAME_BURSTS=4 and a beat-per-cycle burst responder.
module tb_ddr_frame_reader;

  localparam int AW = 25;
  localparam int BL = 8;

  logic          clk = 1'b0;
  logic          sys_rst = 1'b1;
  logic          rd_load = 1'b0;
  logic [1:0]    rd_bank = 2'd0;
  logic          fifo_afull = 1'b0;
  logic          frame_rd_done;
  logic          busy;
  logic          rd_err;
  logic          ready_r = 1'b1;
  logic          resp_v = 1'b0;
  logic          man_v = 1'b0;

  int            errors = 0;
  int            checks = 0;
  int            cyc = 0;
  int            acc_cnt = 0;
  int            tb_beats = 0;
  int            done_cnt = 0;
  int            done_cyc = 0;
  int            beat_cyc = 0;
  int            beats_left = 0;
  int            drop_cyc = 0;
  int            d0;
  logic          ok;
  logic [AW-1:0] addr_log [0:63];
  int            acc_cyc [0:63];

  ddr_frame_reader_if #(.ADDR_W(AW)) ifc ();

  assign ifc.cmd_ready   = ready_r;
  assign ifc.rdata_valid = resp_v | man_v;

  ddr_frame_reader #(
    .ADDR_W(AW),
    .BURST_LEN(BL),
    .FRAME_BURSTS(4),
    .CNT_W(3)
  ) dut (
    .ddr_clk(clk),
    .sys_rst(sys_rst),
    .rd_load(rd_load),
    .rd_bank(rd_bank),
    .fifo_afull(fifo_afull),
    .ddr(ifc.master),
    .frame_rd_done(frame_rd_done),
    .busy(busy),
    .rd_err(rd_err)
  );

  always #5 clk = ~clk;

  // Arbiter/memory model: logs commands, returns BL beats after each accept.
  always @(posedge clk) begin
    cyc++;
    if (ifc.cmd_valid && ifc.cmd_ready) begin
      if (acc_cnt < 64) begin
        addr_log[acc_cnt] = ifc.cmd_addr;
        acc_cyc[acc_cnt]  = cyc;
      end
      acc_cnt++;
      beats_left = BL;
    end
    if (ifc.rdata_valid) begin
      tb_beats++;
      beat_cyc = cyc;
    end
    if (frame_rd_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    #1;
    resp_v = beats_left > 0;
    if (beats_left > 0) beats_left--;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic clr();
    acc_cnt  = 0;
    tb_beats = 0;
    done_cnt = 0;
  endtask

  task automatic load(input logic [1:0] b);
    rd_bank = b;
    rd_load = 1'b1;
    step(1);
    rd_load = 1'b0;
    rd_bank = ~b;
  endtask

  task automatic wait_acc(input int n, input string tag);
    int k = 0;
    while (acc_cnt < n && k < 300) begin
      step(1);
      k++;
    end
    chk(tag, 32'(acc_cnt >= n), 32'd1);
  endtask

  task automatic wait_done(input int n, input string tag);
    int k = 0;
    while (done_cnt < n && k < 300) begin
      step(1);
      k++;
    end
    chk(tag, 32'(done_cnt >= n), 32'd1);
  endtask

  initial begin
    step(3);
    chk("rst_valid", 32'(ifc.cmd_valid), 32'd0);
    chk("rst_addr", 32'(ifc.cmd_addr), 32'd0);
    chk("rst_done", 32'(frame_rd_done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(rd_err), 32'd0);
    sys_rst = 1'b0;
    step(2);

`ifdef FRAME_RD_LOOP_EN
    clr();
    load(2'd0);
    wait_done(2, "loop_wait");
    chk("loop_beats", 32'(tb_beats), 32'd64);
    chk("loop_acc", 32'(acc_cnt), 32'd8);
    chk("loop_a4", 32'(addr_log[4]), 32'h0000000);
    chk("loop_a7", 32'(addr_log[7]), 32'h0000018);
    chk("loop_busy", 32'(busy), 32'd1);
    chk("loop_err", 32'(rd_err), 32'd0);
`else
    // Single frame from bank 2.
    clr();
    load(2'd2);
    chk("lat_v0", 32'(ifc.cmd_valid), 32'd0);
    chk("lat_busy", 32'(busy), 32'd1);
    step(1);
    chk("lat_v1", 32'(ifc.cmd_valid), 32'd1);
    chk("lat_addr", 32'(ifc.cmd_addr), 32'h1000000);
    wait_done(1, "f1_wait");
    step(3);
    chk("f1_acc", 32'(acc_cnt), 32'd4);
    chk("f1_a0", 32'(addr_log[0]), 32'h1000000);
    chk("f1_a1", 32'(addr_log[1]), 32'h1000008);
    chk("f1_a2", 32'(addr_log[2]), 32'h1000010);
    chk("f1_a3", 32'(addr_log[3]), 32'h1000018);
    chk("f1_beats", 32'(tb_beats), 32'd32);
    chk("f1_done_lat", 32'(done_cyc - beat_cyc), 32'd1);
    chk("f1_done_cnt", 32'(done_cnt), 32'd1);
    chk("f1_busy", 32'(busy), 32'd0);

    // Almost-full hold after burst 1.
    clr();
    load(2'd0);
    wait_acc(1, "af_wait");
    fifo_afull = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      ok = ok | ifc.cmd_valid;
    end
    chk("af_no_valid", 32'(ok), 32'd0);
    chk("af_acc_hold", 32'(acc_cnt), 32'd1);
    fifo_afull = 1'b0;
    drop_cyc = cyc;
    wait_done(1, "af_done");
    step(3);
    chk("af_issue_lat", 32'(acc_cyc[1] - drop_cyc), 32'd2);
    chk("af_beats", 32'(tb_beats), 32'd32);
    chk("af_done_cnt", 32'(done_cnt), 32'd1);

    // Back-pressure on the command channel.
    clr();
    ready_r = 1'b0;
    load(2'd1);
    step(1);
    chk("bp_v", 32'(ifc.cmd_valid), 32'd1);
    chk("bp_addr", 32'(ifc.cmd_addr), 32'h0800000);
    fifo_afull = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(1);
      ok = ok & ifc.cmd_valid & (ifc.cmd_addr == 25'h0800000);
    end
    chk("bp_hold", 32'(ok), 32'd1);
    ready_r = 1'b1;
    fifo_afull = 1'b0;
    step(1);
    chk("bp_drop", 32'(ifc.cmd_valid), 32'd0);
    chk("bp_acc", 32'(acc_cnt), 32'd1);
    wait_done(1, "bp_done");
    step(3);
    chk("bp_acc_all", 32'(acc_cnt), 32'd4);

    // Loads while busy: last one wins at the frame boundary.
    clr();
    load(2'd0);
    wait_acc(1, "pd_wait");
    load(2'd1);
    step(3);
    load(2'd3);
    wait_done(2, "pd_done");
    step(3);
    chk("pd_acc", 32'(acc_cnt), 32'd8);
    chk("pd_a0", 32'(addr_log[0]), 32'h0000000);
    chk("pd_a3", 32'(addr_log[3]), 32'h0000018);
    chk("pd_a4", 32'(addr_log[4]), 32'h1800000);
    chk("pd_a5", 32'(addr_log[5]), 32'h1800008);
    chk("pd_a7", 32'(addr_log[7]), 32'h1800018);
    chk("pd_beats", 32'(tb_beats), 32'd64);
    chk("pd_busy", 32'(busy), 32'd0);
    chk("pd_err", 32'(rd_err), 32'd0);

    // Stray beat while idle, then reset mid-frame.
    man_v = 1'b1;
    step(1);
    man_v = 1'b0;
    chk("err_set", 32'(rd_err), 32'd1);
    step(3);
    chk("err_sticky", 32'(rd_err), 32'd1);
    clr();
    load(2'd2);
    wait_acc(2, "rst_wait");
    step(2);
    sys_rst = 1'b1;
    step(1);
    sys_rst = 1'b0;
    d0 = done_cnt;
    chk("mr_valid", 32'(ifc.cmd_valid), 32'd0);
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_err_clr", 32'(rd_err), 32'd0);
    step(1);
    chk("mr_no_done", 32'(frame_rd_done), 32'd0);
    step(1);
    chk("mr_err_late", 32'(rd_err), 32'd1);
    step(10);
    chk("mr_done_cnt", 32'(done_cnt), 32'(d0));
    chk("mr_idle", 32'(busy), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
